aes_stream_loader: RTL and testbench

//  Byte-stream front/back end for the AES encryptor datapath. Assembles 16 input bytes into a
//  128-bit plaintext block, launches the encryptor with a start pulse, waits for its done flag,

---
 rtl/aes_stream_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_aes_stream_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_loader.sv
// Byte-stream front/back end for the AES encryptor: packs 16 bytes into a block, launches it,
// waits for the ciphertext and streams it out byte by byte. Optional PKCS#7 padding: AES_PKCS7_PAD_EN.
module aes_stream_loader #(
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_wr,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] enc_pt,
  output logic [127:0] enc_key,
  output logic         enc_start,
  input  logic [127:0] enc_ct,
  input  logic         enc_done,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         err
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NBYTES = 16;
  localparam int unsigned WCNT_W = $clog2(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [CNT_W-1:0]   ocnt_q, ocnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [BLK_W-1:0]   pt_q, pt_d;
  logic [BLK_W-1:0]   ct_q, ct_d;
  logic [BLK_W-1:0]   key_q, key_d;
  logic [BLK_W-1:0]   enc_key_q, enc_key_d;
  logic [BLK_W-1:0]   enc_pt_q, enc_pt_d;
  logic               last_q, last_d;
  logic               pad_pend_q, pad_pend_d;
  logic               enc_start_q, enc_start_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [BLK_W-1:0]   shifted;

  assign shifted = {pt_q[BLK_W-BYTE_W-1:0], in_data};

`ifdef AES_PKCS7_PAD_EN
  logic [CNT_W-1:0]   pad_n;
  logic [BLK_W-1:0]   pad_pat;
  logic [BLK_W-1:0]   padded;

  // Left-justify the n received bytes and fill the tail with (16-n) copies of 16-n.
  always_comb begin
    pad_n   = CNT_W'(NBYTES - 1) - bcnt_q;
    pad_pat = '0;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (CNT_W'(k) < pad_n) pad_pat[k*BYTE_W +: BYTE_W] = {4'h0, pad_n};
    end
    padded = (shifted << {pad_n, 3'b000}) | pad_pat;
  end
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    ocnt_d     = ocnt_q;
    wcnt_d     = wcnt_q;
    pt_d       = pt_q;
    ct_d       = ct_q;
    key_d      = key_wr ? key_in : key_q;
    enc_key_d  = enc_key_q;
    enc_pt_d   = enc_pt_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;
    err_d      = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          if (in_last && (bcnt_q != CNT_W'(NBYTES - 1))) begin
`ifdef AES_PKCS7_PAD_EN
            pt_d    = padded;
            bcnt_d  = '0;
            last_d  = 1'b1;
            state_d = ST_LAUNCH;
`else
            pt_d    = '0;
            bcnt_d  = '0;
            err_d   = 1'b1;
`endif
          end else begin
            pt_d   = shifted;
            bcnt_d = bcnt_q + CNT_W'(1);
            if (bcnt_q == CNT_W'(NBYTES - 1)) begin
              state_d = ST_LAUNCH;
              last_d  = in_last;
`ifdef AES_PKCS7_PAD_EN
              pad_pend_d = in_last;
`endif
            end
          end
        end
      end

      ST_LAUNCH: begin
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (enc_done) begin
          ct_d    = enc_ct;
          ocnt_d  = '0;
          state_d = ST_DRAIN;
        end else if (wcnt_q == WCNT_W'(WAIT_TIMEOUT - 1)) begin
          err_d      = 1'b1;
          pt_d       = '0;
          bcnt_d     = '0;
          last_d     = 1'b0;
          pad_pend_d = 1'b0;
          state_d    = ST_FILL;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      ST_DRAIN: begin
        if (out_ready) begin
          ct_d   = {ct_q[BLK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
          ocnt_d = ocnt_q + CNT_W'(1);
          if (ocnt_q == CNT_W'(NBYTES - 1)) begin
            if (pad_pend_q) begin
              // Message ended on a block boundary: follow with a full block of pad bytes.
              pt_d       = {NBYTES{8'h10}};
              pad_pend_d = 1'b0;
              state_d    = ST_LAUNCH;
            end else begin
              last_d  = 1'b0;
              state_d = ST_FILL;
            end
          end
        end
      end

      default: state_d = ST_FILL;
    endcase

    // Launch operands are frozen on entry to LAUNCH so they are valid alongside enc_start.
    if (state_d == ST_LAUNCH) begin
      enc_pt_d  = pt_d;
      enc_key_d = key_d;
    end

    enc_start_d = (state_d == ST_LAUNCH);
    out_valid_d = (state_d == ST_DRAIN);
    out_last_d  = (state_d == ST_DRAIN) && (ocnt_d == CNT_W'(NBYTES - 1)) && last_d && !pad_pend_d;
    busy_d      = (state_d != ST_FILL) || (bcnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      bcnt_q      <= '0;
      ocnt_q      <= '0;
      wcnt_q      <= '0;
      pt_q        <= '0;
      ct_q        <= '0;
      key_q       <= '0;
      enc_key_q   <= '0;
      enc_pt_q    <= '0;
      last_q      <= 1'b0;
      pad_pend_q  <= 1'b0;
      enc_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      ocnt_q      <= ocnt_d;
      wcnt_q      <= wcnt_d;
      pt_q        <= pt_d;
      ct_q        <= ct_d;
      key_q       <= key_d;
      enc_key_q   <= enc_key_d;
      enc_pt_q    <= enc_pt_d;
      last_q      <= last_d;
      pad_pend_q  <= pad_pend_d;
      enc_start_q <= enc_start_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == ST_FILL);
  assign enc_pt    = enc_pt_q;
  assign enc_key   = enc_key_q;
  assign enc_start = enc_start_q;
  assign out_data  = ct_q[BLK_W-1 -: BYTE_W];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Scoreboard bench for aes_stream_loader with a stub encryptor that answers 3 cycles after start.
module tb_aes_stream_loader;

  localparam int unsigned TO = 16;
  localparam logic [127:0] VEC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2    = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] PAD_BLK = {16{8'h10}};

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_wr;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] enc_pt;
  logic [127:0] enc_key;
  logic         enc_start;
  logic [127:0] enc_ct = '0;
  logic         enc_done = 1'b0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic         busy;
  logic         err;

  aes_stream_loader #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_wr(key_wr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .enc_pt(enc_pt), .enc_key(enc_key), .enc_start(enc_start),
    .enc_ct(enc_ct), .enc_done(enc_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int ov_cnt = 0;
  int pop_cnt = 0;
  int enc_delay = 0;
  bit done_en = 1'b1;
  bit alt_ready = 1'b0;
  logic [127:0] pt_at_start = '0;
  logic [127:0] key_at_start = '0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] key);
    if (pt == VEC_PT && key == VEC_KEY) return VEC_CT;
    return pt ^ key ^ 128'h5a5a_0000_ffff_1234_8765_c3c3_0f0f_a5a5;
  endfunction

  task automatic push_ct(input logic [127:0] ct, input bit last);
    for (int i = 0; i < 16; i++)
      exp_q.push_back({last && (i == 15), ct[127 - 8*i -: 8]});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stub encryptor plus err/out_valid bookkeeping.
  always @(negedge clk) begin
    enc_done = 1'b0;
    if (enc_delay != 0) begin
      enc_delay--;
      if (enc_delay == 0 && done_en) begin
        enc_ct   = model_ct(pt_at_start, key_at_start);
        enc_done = 1'b1;
      end
    end
    if (enc_start) begin
      start_cnt++;
      start_cyc    = cyc;
      pt_at_start  = enc_pt;
      key_at_start = enc_key;
      enc_delay    = 3;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (out_valid) ov_cnt++;
  end

  // Output sink: every presented byte must match the scoreboard head, popped on handshake.
  always @(negedge clk) begin
    out_ready = alt_ready ? ~out_ready : 1'b1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {119'd0, out_last, out_data}, 128'h1ff);
      end else begin
        check("out_byte", {119'd0, out_last, out_data}, {119'd0, exp_q[0]});
        if (out_ready) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] v, input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = v[127 - 8*i -: 8];
      in_last  = last && (i == n - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_start(input int s0, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (start_cnt != s0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(tag, {127'd0, ok}, 128'd1);
  endtask

  task automatic wait_drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (exp_q.size() == 0 && !out_valid && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {127'd0, ok}, 128'd1);
  endtask

  initial begin
    int s0, e0, v0, p0;
    bit ok;
    rst = 1'b0; key_in = '0; key_wr = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    step(); step();
    check("rst_enc_start", {127'd0, enc_start}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_last", {127'd0, out_last}, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_enc_pt", enc_pt, 128'd0);
    check("rst_enc_key", enc_key, 128'd0);
    rst = 1'b1;
    step();
    key_in = VEC_KEY; key_wr = 1'b1;
    step();
    key_wr = 1'b0;

    // 1: known-answer block, free-flowing sink, stray input while busy is ignored
    s0 = start_cnt;
`ifdef AES_PKCS7_PAD_EN
    push_ct(VEC_CT, 1'b0);
    push_ct(model_ct(PAD_BLK, VEC_KEY), 1'b1);
`else
    push_ct(VEC_CT, 1'b1);
`endif
    send(VEC_PT, 16, 1'b1);
    wait_start(s0, "t1_start_seen");
    check("t1_enc_pt", pt_at_start, VEC_PT);
    check("t1_enc_key", key_at_start, VEC_KEY);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hee;
      check("t1_in_ready_busy", {127'd0, in_ready}, 128'd0);
      check("t1_busy", {127'd0, busy}, 128'd1);
      step();
    end
    in_valid = 1'b0;
    wait_drain("t1_drained");
`ifdef AES_PKCS7_PAD_EN
    check("t1_starts", 128'(start_cnt - s0), 128'd2);
`else
    check("t1_starts", 128'(start_cnt - s0), 128'd1);
`endif

    // 2: same block against a sink that stalls every other cycle
    s0 = start_cnt;
    alt_ready = 1'b1;
`ifdef AES_PKCS7_PAD_EN
    push_ct(VEC_CT, 1'b0);
    push_ct(model_ct(PAD_BLK, VEC_KEY), 1'b1);
`else
    push_ct(VEC_CT, 1'b1);
`endif
    send(VEC_PT, 16, 1'b1);
    wait_drain("t2_drained");
    alt_ready = 1'b0;
    check("t2_enc_pt", enc_pt, VEC_PT ^ ((start_cnt - s0 == 2) ? (VEC_PT ^ PAD_BLK) : '0));

    // 3: encryptor never answers -> single timeout error pulse
    done_en = 1'b0;
    s0 = start_cnt; e0 = err_cnt; v0 = ov_cnt;
    send(VEC_PT, 16, 1'b0);
    wait_start(s0, "t3_start_seen");
    for (int i = 0; i < int'(TO) + 8; i++) step();
    check("t3_err_pulses", 128'(err_cnt - e0), 128'd1);
    check("t3_err_delay", 128'(err_cyc - start_cyc), 128'(TO + 1));
    check("t3_no_out_valid", 128'(ov_cnt - v0), 128'd0);
    check("t3_in_ready", {127'd0, in_ready}, 128'd1);
    check("t3_busy", {127'd0, busy}, 128'd0);
    done_en = 1'b1;

    // 4: short block of 5 bytes
    s0 = start_cnt; e0 = err_cnt;
`ifdef AES_PKCS7_PAD_EN
    push_ct(model_ct({40'ha0a1a2a3a4, {11{8'h0b}}}, VEC_KEY), 1'b1);
    send({40'ha0a1a2a3a4, 88'd0}, 5, 1'b1);
    wait_start(s0, "t4_start_seen");
    check("t4_padded_pt", pt_at_start, {40'ha0a1a2a3a4, {11{8'h0b}}});
    wait_drain("t4_drained");
    check("t4_err", 128'(err_cnt - e0), 128'd0);
`else
    send({40'ha0a1a2a3a4, 88'd0}, 5, 1'b1);
    step(); step();
    check("t4_err", 128'(err_cnt - e0), 128'd1);
    check("t4_no_start", 128'(start_cnt - s0), 128'd0);
    check("t4_in_ready", {127'd0, in_ready}, 128'd1);
    check("t4_busy", {127'd0, busy}, 128'd0);
`endif

    // 5: key rewritten while a block is in flight
    s0 = start_cnt;
    push_ct(model_ct(128'h0f0e0d0c0b0a09080706050403020100, VEC_KEY), 1'b0);
    send(128'h0f0e0d0c0b0a09080706050403020100, 16, 1'b0);
    wait_start(s0, "t5_start_seen");
    step();
    key_in = KEY2; key_wr = 1'b1;
    step();
    key_wr = 1'b0;
    check("t5_enc_key_held", enc_key, VEC_KEY);
    wait_drain("t5_drained");
    s0 = start_cnt;
    push_ct(model_ct(128'hdeadbeef_01234567_89abcdef_cafef00d, KEY2), 1'b0);
    send(128'hdeadbeef_01234567_89abcdef_cafef00d, 16, 1'b0);
    wait_start(s0, "t5b_start_seen");
    check("t5_new_key", key_at_start, KEY2);
    wait_drain("t5b_drained");

    // 6: reset while the 7th ciphertext byte is on the output
    s0 = start_cnt;
    push_ct(model_ct(VEC_PT, KEY2), 1'b0);
    send(VEC_PT, 16, 1'b0);
    p0 = pop_cnt;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pop_cnt - p0 == 7) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("t6_reached_byte7", {127'd0, ok}, 128'd1);
    check("t6_out_valid_pre", {127'd0, out_valid}, 128'd1);
    rst = 1'b0;
    #1;
    check("t6_out_valid_async", {127'd0, out_valid}, 128'd0);
    exp_q.delete();
    step();
    rst = 1'b1;
    step(); step();
    check("t6_in_ready", {127'd0, in_ready}, 128'd1);
    check("t6_busy", {127'd0, busy}, 128'd0);
    check("t6_out_valid", {127'd0, out_valid}, 128'd0);
    check("t6_enc_key", enc_key, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
